// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode codes, flag bit positions, sequencer states
// and the status-register merge rule.
package alu_pkg;

   localparam logic [3:0] ADD  = 4'h0;
   localparam logic [3:0] SUB  = 4'h1;
   localparam logic [3:0] BUF1 = 4'h2;
   localparam logic [3:0] BUF2 = 4'h3;
   localparam logic [3:0] AND  = 4'h4;
   localparam logic [3:0] OR   = 4'h5;
   localparam logic [3:0] XOR  = 4'h6;
   localparam logic [3:0] RSUB = 4'h7;
   localparam logic [3:0] INC  = 4'h8;
   localparam logic [3:0] DEC  = 4'h9;
   localparam logic [3:0] ROL  = 4'hA;
   localparam logic [3:0] ROR  = 4'hB;
   localparam logic [3:0] SHL  = 4'hC;
   localparam logic [3:0] SHR  = 4'hD;
   localparam logic [3:0] ASR  = 4'hE;
   localparam logic [3:0] NEG  = 4'hF;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_S = 1;
   localparam int FLAG_O = 0;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      EXEC,
      WB
   } state_t;

   function automatic logic is_arith(input logic [3:0] mode);
      return (mode == ADD) || (mode == SUB) || (mode == RSUB) ||
             (mode == INC) || (mode == DEC) || (mode == NEG);
   endfunction

   // C and O from the ALU are meaningless for non-arithmetic modes
   function automatic logic [3:0] sr_merge(
      input logic [3:0] old_sr,
      input logic [3:0] alu_sr,
      input logic [3:0] mode
   );
      logic [3:0] r;
      r = old_sr;
      r[FLAG_Z] = alu_sr[FLAG_Z];
      r[FLAG_S] = alu_sr[FLAG_S];
      if (is_arith(mode)) begin
         r[FLAG_C] = alu_sr[FLAG_C];
         r[FLAG_O] = alu_sr[FLAG_O];
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_exec_ctrl.sv
// Execution-stage sequencer for the 8-bit ALU: operand fetch, ALU drive,
// result/flag capture and write-back to accumulator or data memory.
module alu_exec_ctrl
   import alu_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DMEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_mode,
   input  logic              cmd_op1_imm,
   input  logic [7:0]        cmd_imm,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_dst_mem,
   input  logic              cmd_flags_we,
   output logic              dmem_re,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   input  logic [7:0]        dmem_rdata,
   output logic [7:0]        dmem_di,
   output logic              alu_e,
   output logic [3:0]        alu_mode,
   output logic [7:0]        alu_op1,
   output logic [7:0]        alu_op2,
   output logic [3:0]        alu_cflags,
   input  logic [3:0]        alu_flags,
   input  logic [7:0]        alu_out,
   output logic [7:0]        acc,
   output logic [3:0]        sr,
   output logic              done
);

   if (DMEM_LAT != 1) begin : g_lat_chk
      $error("alu_exec_ctrl supports only DMEM_LAT == 1");
   end

   state_t state_q, state_d;

   logic [3:0]        mode_q;
   logic [7:0]        op1_q;
   logic [7:0]        op2_q;
   logic [ADDR_W-1:0] addr_q;
   logic              dst_q;
   logic              fwe_q;
   logic [7:0]        res_q;
   logic [3:0]        flg_q;
   logic [7:0]        acc_q;
   logic [3:0]        sr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      dmem_re   = 1'b0;
      dmem_we   = 1'b0;
      alu_e     = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_d = FETCH;
         end
         FETCH: begin
            dmem_re = 1'b1;
            state_d = EXEC;
         end
         EXEC: begin
            alu_e   = 1'b1;
            state_d = WB;
         end
         WB: begin
            done    = 1'b1;
            dmem_we = dst_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand1 is frozen at acceptance so a later acc write cannot leak in
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= '0;
         op1_q  <= '0;
         op2_q  <= '0;
         addr_q <= '0;
         dst_q  <= 1'b0;
         fwe_q  <= 1'b0;
         res_q  <= '0;
         flg_q  <= '0;
         acc_q  <= '0;
         sr_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  mode_q <= cmd_mode;
                  op1_q  <= cmd_op1_imm ? cmd_imm : acc_q;
                  addr_q <= cmd_addr;
                  dst_q  <= cmd_dst_mem;
                  fwe_q  <= cmd_flags_we;
               end
            end
            EXEC: begin
               op2_q <= dmem_rdata;
               res_q <= alu_out;
               flg_q <= alu_flags;
            end
            WB: begin
               if (!dst_q) acc_q <= res_q;
               if (fwe_q)  sr_q  <= sr_merge(sr_q, flg_q, mode_q);
            end
            default: ;
         endcase
      end
   end

   assign dmem_addr  = addr_q;
   assign dmem_di    = res_q;
   assign alu_mode   = mode_q;
   assign alu_op1    = op1_q;
   assign alu_op2    = alu_e ? dmem_rdata : op2_q;
   assign alu_cflags = sr_q;
   assign acc        = acc_q;
   assign sr         = sr_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural ALU and data memory around the DUT,
// directed plus random operations checked against an arithmetic reference.
module tb_alu_exec_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_mode = '0;
   logic       cmd_op1_imm = 1'b0;
   logic [7:0] cmd_imm = '0;
   logic [7:0] cmd_addr = '0;
   logic       cmd_dst_mem = 1'b0;
   logic       cmd_flags_we = 1'b0;
   logic       dmem_re, dmem_we;
   logic [7:0] dmem_addr;
   logic [7:0] dmem_rdata = '0;
   logic [7:0] dmem_di;
   logic       alu_e;
   logic [3:0] alu_mode;
   logic [7:0] alu_op1, alu_op2;
   logic [3:0] alu_cflags;
   logic [3:0] alu_flags;
   logic [7:0] alu_out;
   logic [7:0] acc;
   logic [3:0] sr;
   logic       done;

   alu_exec_ctrl #(.ADDR_W(8), .DMEM_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_op1_imm(cmd_op1_imm),
      .cmd_imm(cmd_imm), .cmd_addr(cmd_addr),
      .cmd_dst_mem(cmd_dst_mem), .cmd_flags_we(cmd_flags_we),
      .dmem_re(dmem_re), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
      .dmem_di(dmem_di), .alu_e(alu_e), .alu_mode(alu_mode),
      .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_cflags(alu_cflags), .alu_flags(alu_flags),
      .alu_out(alu_out), .acc(acc), .sr(sr), .done(done)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [256];
   logic [7:0] exp_mem [256];
   logic [7:0] exp_acc = '0;
   logic [3:0] exp_sr = '0;
   int n_chk = 0;
   int n_fail = 0;

   always @(posedge clk) begin
      if (dmem_re) dmem_rdata <= mem[dmem_addr];
      if (dmem_we) mem[dmem_addr] <= dmem_di;
   end

   // Reference ALU: returns {Z,C,S,O, result}
   function automatic logic [11:0] alu_ref(
      input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
      int ua, ub, sa, sb, u, s;
      logic [7:0] r;
      logic c, o, ar;
      ua = int'(a); ub = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      u = 0; s = 0; ar = 1'b1;
      r = '0; c = a[0]; o = b[0];
      case (m)
         4'h0: begin u = ua + ub; s = sa + sb; end
         4'h1: begin u = ua - ub; s = sa - sb; end
         4'h7: begin u = ub - ua; s = sb - sa; end
         4'h8: begin u = ua + 1;  s = sa + 1;  end
         4'h9: begin u = ua - 1;  s = sa - 1;  end
         4'hF: begin u = 0 - ua;  s = 0 - sa;  end
         default: ar = 1'b0;
      endcase
      if (ar) begin
         r = u[7:0];
         c = (u < 0) || (u > 255);
         o = (s < -128) || (s > 127);
      end else begin
         case (m)
            4'h2: r = a;
            4'h3: r = b;
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = a ^ b;
            4'hA: r = {a[6:0], a[7]};
            4'hB: r = {a[0], a[7:1]};
            4'hC: r = a << 1;
            4'hD: r = a >> 1;
            default: r = {a[7], a[7:1]};
         endcase
      end
      return {(r == 8'h00), c, r[7], o, r};
   endfunction

   always_comb {alu_flags, alu_out} = alu_ref(alu_mode, alu_op1, alu_op2);

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      while (cmd_ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) chk("ready_timeout", 32'(cmd_ready), 32'd1);
   endtask

   // One full operation with per-phase checks and model update
   task automatic do_op(input logic [3:0] m, input logic op1_imm,
                        input logic [7:0] imm, input logic [7:0] addr,
                        input logic dst, input logic fwe);
      logic [7:0] a, b, r;
      logic [3:0] f;
      logic is_ar;
      @(negedge clk);
      a = op1_imm ? imm : exp_acc;
      b = exp_mem[addr];
      {f, r} = alu_ref(m, a, b);
      is_ar = m inside {4'h0, 4'h1, 4'h7, 4'h8, 4'h9, 4'hF};
      cmd_mode = m; cmd_op1_imm = op1_imm; cmd_imm = imm;
      cmd_addr = addr; cmd_dst_mem = dst; cmd_flags_we = fwe;
      cmd_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("fetch_re", 32'(dmem_re), 32'd1);
      chk("fetch_ready", 32'(cmd_ready), 32'd0);
      chk("fetch_addr", 32'(dmem_addr), 32'(addr));
      @(negedge clk);
      chk("exec_alu_e", 32'(alu_e), 32'd1);
      chk("exec_op1", 32'(alu_op1), 32'(a));
      chk("exec_op2", 32'(alu_op2), 32'(b));
      chk("exec_mode", 32'(alu_mode), 32'(m));
      @(negedge clk);
      chk("wb_done", 32'(done), 32'd1);
      chk("wb_we", 32'(dmem_we), 32'(dst));
      if (dst) exp_mem[addr] = r;
      else     exp_acc = r;
      if (fwe) exp_sr = is_ar ? f : {f[3], exp_sr[2], f[1], exp_sr[0]};
      @(negedge clk);
      chk("idle_ready", 32'(cmd_ready), 32'd1);
      chk("acc", 32'(acc), 32'(exp_acc));
      chk("sr", 32'(sr), 32'(exp_sr));
      chk("cflags", 32'(alu_cflags), 32'(exp_sr));
      chk("mem", 32'(mem[addr]), 32'(exp_mem[addr]));
   endtask

   initial begin
      int hs, last, bad_sp, bad_ex, wes;
      logic [7:0] acc0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom);
         exp_mem[i] = mem[i];
      end
      mem[8'h10] = 8'hFB; exp_mem[8'h10] = 8'hFB;
      mem[8'h30] = 8'h20; exp_mem[8'h30] = 8'h20;
      mem[8'h44] = 8'hFF; exp_mem[8'h44] = 8'hFF;
      mem[8'h50] = 8'h01; exp_mem[8'h50] = 8'h01;

      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_acc", 32'(acc), 32'd0);
      chk("rst_sr", 32'(sr), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_re", 32'(dmem_re), 32'd0);
      chk("rst_we", 32'(dmem_we), 32'd0);
      chk("rst_alu_e", 32'(alu_e), 32'd0);
      chk("rst_addr", 32'(dmem_addr), 32'd0);
      chk("rst_op1", 32'(alu_op1), 32'd0);
      rst = 1'b0;

      do_op(4'h2, 1'b1, 8'h05, 8'h10, 1'b0, 1'b0);
      chk("buf1_acc", 32'(acc), 32'h05);
      do_op(4'h0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b1);
      chk("add_acc", 32'(acc), 32'h00);
      chk("add_sr", 32'(sr), 32'hC);
      do_op(4'h1, 1'b1, 8'h10, 8'h30, 1'b1, 1'b1);
      chk("sub_mem", 32'(mem[8'h30]), 32'hF0);
      chk("sub_s", 32'(sr[1]), 32'd1);
      chk("sub_acc", 32'(acc), 32'h00);
      chk("pre_and_c", 32'(sr[2]), 32'd1);
      do_op(4'h4, 1'b1, 8'h80, 8'h44, 1'b0, 1'b1);
      chk("and_acc", 32'(acc), 32'h80);
      chk("and_zcs", 32'(sr[3:1]), 32'b011);
      do_op(4'h0, 1'b1, 8'hFF, 8'h50, 1'b0, 1'b0);
      chk("nofwe_acc", 32'(acc), 32'h00);
      chk("nofwe_sr", 32'(sr), 32'(exp_sr));

      // three INCs with cmd_valid held high throughout
      @(negedge clk);
      acc0 = acc;
      cmd_mode = 4'h8; cmd_op1_imm = 1'b0; cmd_addr = 8'h01;
      cmd_dst_mem = 1'b0; cmd_flags_we = 1'b0; cmd_valid = 1'b1;
      hs = 0; last = 0; bad_sp = 0; bad_ex = 0;
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge clk);
         if (32'(dmem_re) + 32'(dmem_we) + 32'(alu_e) > 1) bad_ex++;
         if (cmd_ready && cmd_valid) begin
            if (hs > 0 && c - last != 4) bad_sp++;
            last = c;
            hs++;
            if (hs == 3) begin
               @(posedge clk);
               #1 cmd_valid = 1'b0;
            end
         end
      end
      exp_acc = acc0 + 8'd3;
      chk("held_hs", 32'(hs), 32'd3);
      chk("held_spacing", 32'(bad_sp), 32'd0);
      chk("held_excl", 32'(bad_ex), 32'd0);
      chk("held_acc", 32'(acc), 32'(exp_acc));

      // reset during EXEC of a memory-destination op
      @(negedge clk);
      cmd_mode = 4'h5; cmd_op1_imm = 1'b1; cmd_imm = 8'h3C;
      cmd_addr = 8'h40; cmd_dst_mem = 1'b1; cmd_flags_we = 1'b1;
      cmd_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_exec", 32'(alu_e), 32'd1);
      rst = 1'b1;
      wes = 0;
      #1 if (dmem_we) wes++;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (dmem_we) wes++;
      end
      rst = 1'b0;
      exp_acc = '0; exp_sr = '0;
      @(negedge clk);
      if (dmem_we) wes++;
      chk("rst_no_we", 32'(wes), 32'd0);
      chk("rst_mid_acc", 32'(acc), 32'd0);
      chk("rst_mid_sr", 32'(sr), 32'd0);
      chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
      chk("rst_mid_mem", 32'(mem[8'h40]), 32'(exp_mem[8'h40]));

      for (int i = 0; i < 24; i++)
         do_op(4'($urandom), 1'($urandom), 8'($urandom),
               8'($urandom), 1'($urandom), 1'($urandom));

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execution-stage sequencer sitting in front of the combinational 8-bit ALU. It accepts one decoded operation at a time, fetches Operand2 from data memory, drives the ALU enable, mode and operands, then captures the ALU result and flags. It owns the accumulator and the 4-bit status register, and writes the result back to the accumulator or to data memory, so the ALU's flag/result outputs terminate here.

## Interface
Parameters:
- ADDR_W, 8, data-memory address width
- DMEM_LAT, 1, data-memory read latency in cycles; only 1 is supported

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle; command accepted when valid & ready
- cmd_mode  in  4  ALU mode code, passed to ALU unchanged
- cmd_op1_imm  in  1  Operand1 source: 0 = accumulator, 1 = cmd_imm
- cmd_imm  in  8  immediate Operand1
- cmd_addr  in  ADDR_W  data-memory address for Operand2 and for write-back
- cmd_dst_mem  in  1  destination: 0 = accumulator, 1 = data memory at cmd_addr
- cmd_flags_we  in  1  update status register
- dmem_re  out  1  read strobe
- dmem_we  out  1  write strobe
- dmem_addr  out  ADDR_W  memory address
- dmem_rdata  in  8  read data, valid one cycle after dmem_re
- dmem_di  out  8  write data
- alu_e  out  1  ALU enable
- alu_mode  out  4  ALU mode
- alu_op1, alu_op2  out  8  ALU operands
- alu_cflags  out  4  current status register, {Z,C,S,O}
- alu_flags  in  4  ALU flag result, {Z,C,S,O}
- alu_out  in  8  ALU result
- acc  out  8  accumulator
- sr  out  4  status register {Z,C,S,O}
- done  out  1  one-cycle pulse on retirement

## Operation
- States: IDLE, FETCH, EXEC, WB.
- IDLE: cmd_ready=1. On handshake, register mode, op1 source/value, addr, dst, flags_we; go to FETCH.
- FETCH: dmem_re=1, dmem_addr=addr; go to EXEC.
- EXEC: alu_e=1, alu_mode=registered mode, alu_op1=imm or acc (acc sampled at acceptance), alu_op2=dmem_rdata; capture alu_out into result register; go to WB.
- WB: done=1. If dst_mem, dmem_we=1, dmem_addr=addr, dmem_di=result; else acc<=result. If flags_we: Z,S always load. C,O load only for arithmetic modes 0000,0001,0111,1000,1001,1111; other modes keep the previous C,O, because ALU carry is undefined there. Then go to IDLE.
- alu_op1, alu_op2 and alu_mode are held at their registered values outside EXEC (no toggling); alu_e=0 outside EXEC.
- Strobes dmem_re, dmem_we and alu_e are mutually exclusive.

## Timing
- Reset values: state IDLE, cmd_ready=1, acc=0x00, sr=0x0, done=0, dmem_re/we=0, alu_e=0, all data/address outputs 0.
- Handshake at edge T. FETCH runs T..T+1, EXEC T+1..T+2, and WB/done T+2..T+3. cmd_ready reasserts at T+3. Throughput is one operation per 4 cycles.
- cmd_valid while busy is ignored (cmd_ready=0); the command must be held.
- Back-to-back: the accumulator written in WB is visible as Operand1 to the next accepted command.
- Reset mid-operation: aborts immediately. No dmem write occurs, and acc/sr are cleared.
- Address wrap: none internal; cmd_addr is used verbatim.

## Structure
- Shared package alu_pkg: 4-bit mode constants (ADD, SUB, BUF1, BUF2, AND, OR, XOR, RSUB, INC, DEC, ROL, ROR, SHL, SHR, ASR, NEG), flag bit indices (Z=3, C=2, S=1, O=0), state enum, and the is_arith(mode) function.
- No sub-module. The status-register merge is a package function, not a separate block.

## Test plan
- Reset, then acc=0x05 via BUF1 with imm=0x05, dst acc. Then ADD with op1=acc and mem[0x10]=0xFB, flags_we → acc=0x00, sr={Z1,C1,S0,O0}, done at T+2.
- SUB with imm=0x10 and mem=0x20, dst_mem, addr 0x30 → mem[0x30]=0xF0, sr.S=1, acc unchanged.
- AND with sr.C=1 beforehand, result 0x80 → sr={Z0,C1(kept),S1,O kept}.
- cmd_valid held high continuously with 3 commands → exactly 3 handshakes at 4-cycle spacing, no overlap of dmem_re/alu_e/dmem_we.
- rst asserted during EXEC of a dst_mem command → no dmem_we pulse, acc=0, sr=0, cmd_ready=1 after release.
- flags_we=0 on ADD 0xFF+0x01 → sr unchanged, acc=0x00.
